audio_engine_mc: RTL and testbench

//  Parametrised multi-channel successor to the audio DSP sequencer. Runs a microcode program from

---
 rtl/audio_engine_mc.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_audio_engine_mc.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_engine_mc.sv
// audio_engine_mc: multi-channel microcoded audio MAC engine.
// A program held in coefficient RAM runs once per audio frame. It does signed
// 16x16 MACs over per-channel sample ring buffers and writes scaled 16-bit
// results to a result bank. All of it is visible through a Wishbone slave on
// the dbus, in regions 0x60..0x66.
// Build option: define DSP_SATURATE_EN to make SAVE clamp to [-32768, 32767].
// When it is left undefined, SAVE keeps the low 16 bits of the shifted value.
`timescale 1ns/1ps
module audio_engine_mc #(
  parameter int CHANNELS     = 4,
  parameter int SAMPLE_DEPTH = 256,
  parameter int COEF_DEPTH   = 256,
  parameter int RESULTS      = 8,
  parameter int ACC_W        = 40
) (
  input  logic        ck,
  input  logic        rst_n,
  input  logic        wb_dbus_cyc,
  input  logic        wb_dbus_we,
  input  logic [3:0]  wb_dbus_sel,
  input  logic [31:0] wb_dbus_adr,
  input  logic [31:0] wb_dbus_dat,
  output logic        ack,
  output logic [31:0] rdt,
  input  logic        frame_stb,
  input  logic        sample_we,
  input  logic [2:0]  sample_chan,
  input  logic [15:0] sample_data,
  output logic        ready,
  output logic        overrun
);

  localparam int SA_W = (SAMPLE_DEPTH > 1) ? $clog2(SAMPLE_DEPTH) : 1;
  localparam int CA_W = (COEF_DEPTH > 1) ? $clog2(COEF_DEPTH) : 1;
  localparam int RA_W = (RESULTS > 1) ? $clog2(RESULTS) : 1;
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [7:0] REG_COEF   = 8'h60;
  localparam logic [7:0] REG_RESULT = 8'h61;
  localparam logic [7:0] REG_STATUS = 8'h62;
  localparam logic [7:0] REG_RESET  = 8'h63;
  localparam logic [7:0] REG_INPUT  = 8'h64;
  localparam logic [7:0] REG_CAPT   = 8'h66;

  localparam logic [4:0] OP_CAPT = 5'd1;
  localparam logic [4:0] OP_MAC  = 5'd8;
  localparam logic [4:0] OP_MACZ = 5'd9;
  localparam logic [4:0] OP_SAVE = 5'd10;
  localparam logic [4:0] OP_HALT = 5'd15;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_READ, S_MUL, S_EXEC} state_t;

  // Storage
  logic [31:0] r_coef   [COEF_DEPTH];
  logic [15:0] r_smp    [CHANNELS][SAMPLE_DEPTH];
  logic [15:0] r_result [RESULTS];

  // Sequencer state
  state_t                  r_state;
  logic                    r_ready;
  logic                    r_overrun;
  logic [CA_W-1:0]         r_pc;
  logic [SA_W-1:0]         r_wp;
  logic signed [ACC_W-1:0] r_acc;
  logic [31:0]             r_ir;
  logic [31:0]             r_nx;
  logic [31:0]             r_capture;
  logic signed [15:0]      r_mul_a;
  logic signed [15:0]      r_mul_b;
  logic signed [31:0]      r_prod;

  // Bus state
  logic        r_seen;
  logic        r_allow;
  logic [31:0] w_rd_data;

  // Bus decode: one access per rising edge of cyc
  logic [7:0]      w_region;
  logic            w_access, w_wr, w_rd, w_busy;
  logic            w_coef_wr, w_reset_wr, w_stat_wr, w_input_wr, w_start;
  logic [CA_W-1:0] w_bus_cidx;
  logic [RA_W-1:0] w_bus_ridx;

  assign w_region   = wb_dbus_adr[31:24];
  assign w_access   = wb_dbus_cyc & ~r_seen;
  assign w_wr       = w_access & wb_dbus_we;
  assign w_rd       = w_access & ~wb_dbus_we;
  assign w_busy     = (r_state != S_IDLE);
  assign w_bus_cidx = wb_dbus_adr[2 +: CA_W];
  assign w_bus_ridx = wb_dbus_adr[2 +: RA_W];
  assign w_coef_wr  = w_wr & (w_region == REG_COEF) & ~w_busy;
  assign w_reset_wr = w_wr & (w_region == REG_RESET);
  assign w_stat_wr  = w_wr & (w_region == REG_STATUS);
  assign w_input_wr = w_wr & (w_region == REG_INPUT) & r_allow;
  assign w_start    = w_reset_wr | (frame_stb & ~w_busy);

  logic w_unused;
  assign w_unused = &{1'b0, wb_dbus_sel, wb_dbus_adr[23:12], wb_dbus_adr[0]};

  // Instruction fields
  logic [4:0] w_op;
  logic [7:0] w_off;
  logic [2:0] w_ir_chan;
  assign w_op      = r_ir[31:27];
  assign w_off     = r_ir[26:19];
  assign w_ir_chan = r_ir[18:16];

  // Sample write port: the dedicated port takes priority over a bus INPUT write
  logic            w_smp_we;
  logic [2:0]      w_smp_chan;
  logic [SA_W-1:0] w_smp_addr;
  logic [15:0]     w_smp_data;

  // Select the source of the single sample-RAM write port
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    w_smp_we   = 1'b0;
    w_smp_chan = '0;
    w_smp_addr = '0;
    w_smp_data = '0;
    if (sample_we) begin
      w_smp_we   = 1'b1;
      w_smp_chan = sample_chan;
      w_smp_addr = r_wp;
      w_smp_data = sample_data;
    end else if (w_input_wr) begin
      w_smp_we   = 1'b1;
      w_smp_chan = wb_dbus_adr[11:9];
      w_smp_addr = wb_dbus_adr[1 +: SA_W];
      w_smp_data = wb_dbus_dat[15:0];
    end
  end

  // Sample and coefficient RAM writes
  // NOTE: RAM arrays carry no reset; their contents are undefined until written.
  always_ff @(posedge ck) begin
    if (w_smp_we && (int'(w_smp_chan) < CHANNELS))
      r_smp[w_smp_chan[CH_W-1:0]][w_smp_addr] <= w_smp_data;
    if (w_coef_wr)
      r_coef[w_bus_cidx] <= wb_dbus_dat;
  end

  // Sample read: ring buffer looks back 'offset' frames from the write pointer
  logic [7:0]      w_rd_diff;
  logic [SA_W-1:0] w_rd_addr;
  logic [15:0]     w_smp_rd;
  logic [CA_W-1:0] w_pc_nx;
  assign w_rd_diff = 8'(r_wp) - w_off;
  assign w_rd_addr = w_rd_diff[SA_W-1:0];
  assign w_smp_rd  = (int'(w_ir_chan) < CHANNELS) ? r_smp[w_ir_chan[CH_W-1:0]][w_rd_addr] : 16'd0;
  assign w_pc_nx   = r_pc + 1'b1;

  // Product sign-extension and SAVE scaling
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [ACC_W-1:0] w_shifted;
  logic [15:0]             w_save_val;
  assign w_prod_ext = ACC_W'(r_prod);
  assign w_shifted  = r_acc >>> r_ir[23:19];

`ifdef DSP_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  // Clamp the scaled accumulator to the signed 16-bit range
  always_comb begin
    if (w_shifted > SAT_MAX)
      w_save_val = 16'h7FFF;
    else if (w_shifted < SAT_MIN)
      w_save_val = 16'h8000;
    else
      w_save_val = w_shifted[15:0];
  end
`else
  logic w_unused_sat;
  assign w_unused_sat = ^w_shifted[ACC_W-1:16];
  assign w_save_val   = w_shifted[15:0];
`endif

  // Sequencer FSM: fetch, read sample, multiply, execute; also frame and overrun tracking
  always_ff @(posedge ck or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every register updates from pre-edge values.
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ready   <= 1'b0;
      r_overrun <= 1'b0;
      r_pc      <= '0;
      r_wp      <= '0;
      r_acc     <= '0;
      r_ir      <= '0;
      r_nx      <= '0;
      r_capture <= '0;
      r_mul_a   <= '0;
      r_mul_b   <= '0;
      r_prod    <= '0;
      for (int i = 0; i < RESULTS; i++) r_result[i] <= '0;
    end else begin
      if (w_stat_wr && wb_dbus_dat[1]) r_overrun <= 1'b0;
      if (w_start) begin
        if (frame_stb && !w_busy) r_wp <= r_wp + 1'b1;
        if (frame_stb && w_busy)  r_overrun <= 1'b1;
        r_state <= S_FETCH;
        r_ready <= 1'b0;
        r_pc    <= '0;
        r_acc   <= '0;
      end else begin
        if (frame_stb) r_overrun <= 1'b1;
        case (r_state)
          S_IDLE: r_ready <= 1'b1;
          S_FETCH: begin
            r_ir    <= r_coef[r_pc];
            r_state <= S_READ;
          end
          S_READ: begin
            r_mul_a <= w_smp_rd;
            r_mul_b <= r_ir[15:0];
            r_nx    <= r_coef[w_pc_nx];
            r_state <= S_MUL;
          end
          S_MUL: begin
            r_prod  <= 32'(r_mul_a) * 32'(r_mul_b);
            r_state <= S_EXEC;
          end
          S_EXEC: begin
            case (w_op)
              OP_CAPT: begin
                case (r_ir[21:19])
                  3'd0:    r_capture <= r_nx;
                  3'd1:    r_capture <= r_acc[31:0];
                  3'd2:    r_capture <= {r_mul_a, r_mul_b};
                  default: ;
                endcase
              end
              OP_MAC:  r_acc <= r_acc + w_prod_ext;
              OP_MACZ: r_acc <= w_prod_ext;
              OP_SAVE: r_result[r_ir[RA_W-1:0]] <= w_save_val;
              default: ;
            endcase
            // The last program word halts the run even without an explicit HALT
            if (w_op == OP_HALT || (&r_pc)) begin
              r_state <= S_IDLE;
              r_ready <= 1'b1;
            end else begin
              r_pc    <= w_pc_nx;
              r_state <= S_FETCH;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Bus read data multiplexer
  always_comb begin
    w_rd_data = '0;
    case (w_region)
      REG_COEF:   w_rd_data = r_coef[w_bus_cidx];
      REG_RESULT: w_rd_data = {{16{r_result[w_bus_ridx][15]}}, r_result[w_bus_ridx]};
      REG_STATUS: w_rd_data = {29'd0, w_busy, r_overrun, r_ready};
      REG_CAPT:   w_rd_data = r_capture;
      default:    w_rd_data = '0;
    endcase
  end

  // Bus handshake, read data and control register
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_seen  <= 1'b0;
      ack     <= 1'b0;
      rdt     <= '0;
      r_allow <= 1'b0;
    end else begin
      r_seen <= wb_dbus_cyc;
      ack    <= w_access;
      rdt    <= w_rd ? w_rd_data : 32'd0;
      if (w_stat_wr) r_allow <= wb_dbus_dat[0];
    end
  end

  assign ready   = r_ready;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_audio_engine_mc.sv
// Scoreboard bench for audio_engine_mc. Bus stimulus pushes the expected read
// data into a queue, and a monitor pops and compares it on every ack. The
// monitor also requires rdt == 0 on every cycle with no ack.
`timescale 1ns/1ps
module tb_audio_engine_mc;

  logic        ck = 1'b0;
  logic        rst_n = 1'b1;
  logic        cyc = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'hF;
  logic [31:0] adr = '0;
  logic [31:0] dat = '0;
  logic        ack;
  logic [31:0] rdt;
  logic        frame_stb = 1'b0;
  logic        sample_we = 1'b0;
  logic [2:0]  sample_chan = '0;
  logic [15:0] sample_data = '0;
  logic        ready;
  logic        overrun;

  localparam logic [31:0] A_COEF   = 32'h6000_0000;
  localparam logic [31:0] A_RESULT = 32'h6100_0000;
  localparam logic [31:0] A_STATUS = 32'h6200_0000;
  localparam logic [31:0] A_RESET  = 32'h6300_0000;
  localparam logic [31:0] A_INPUT  = 32'h6400_0000;
  localparam logic [31:0] A_CAPT   = 32'h6600_0000;

`ifdef DSP_SATURATE_EN
  localparam logic [31:0] EXP_SAVE_BIG = 32'h0000_7FFF;
`else
  localparam logic [31:0] EXP_SAVE_BIG = 32'hFFFF_FFFC;
`endif

  always #5 ck = ~ck;

  audio_engine_mc dut (
    .ck          (ck),
    .rst_n       (rst_n),
    .wb_dbus_cyc (cyc),
    .wb_dbus_we  (we),
    .wb_dbus_sel (sel),
    .wb_dbus_adr (adr),
    .wb_dbus_dat (dat),
    .ack         (ack),
    .rdt         (rdt),
    .frame_stb   (frame_stb),
    .sample_we   (sample_we),
    .sample_chan (sample_chan),
    .sample_data (sample_data),
    .ready       (ready),
    .overrun     (overrun)
  );

  typedef struct {
    string       name;
    logic [31:0] data;
    bit          is_rd;
  } sb_t;

  sb_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [4:0] op, input logic [7:0] off,
                                      input logic [2:0] ch, input logic [15:0] g);
    return {op, off, ch, g};
  endfunction

  // Monitor: compare read data on each ack, require rdt == 0 otherwise
  always @(negedge ck) begin
    sb_t e;
    if (ack) begin
      if (exp_q.size() == 0) begin
        check("ack_unexpected", {31'd0, ack}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (e.is_rd) check(e.name, rdt, e.data);
      end
    end else begin
      check("rdt_idle", rdt, 32'd0);
    end
  end

  task automatic bus(input bit w, input logic [31:0] a, input logic [31:0] d,
                     input string nm, input logic [31:0] exp);
    sb_t e;
    int  n;
    e.name  = nm;
    e.data  = exp;
    e.is_rd = !w;
    exp_q.push_back(e);
    @(posedge ck); #1;
    cyc = 1'b1; we = w; adr = a; dat = d;
    n = 0;
    while (ack !== 1'b1 && n < 8) begin
      @(posedge ck); #1;
      n++;
    end
    if (ack !== 1'b1) begin
      check({nm, "_ack_timeout"}, {31'd0, ack}, 32'd1);
      e = exp_q.pop_back();
    end
    cyc = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus(1'b1, a, d, "write", 32'd0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
    bus(1'b0, a, 32'd0, nm, exp);
  endtask

  task automatic load4(input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3);
    wr(A_COEF + 32'd0,  w0);
    wr(A_COEF + 32'd4,  w1);
    wr(A_COEF + 32'd8,  w2);
    wr(A_COEF + 32'd12, w3);
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 3000) begin
      @(posedge ck); #1;
      n++;
    end
    check(nm, {31'd0, ready}, 32'd1);
  endtask

  task automatic pulse_frame();
    @(posedge ck); #1;
    frame_stb = 1'b1;
    @(posedge ck); #1;
    frame_stb = 1'b0;
  endtask

  task automatic port_sample(input logic [2:0] ch, input logic [15:0] d);
    @(posedge ck); #1;
    sample_we = 1'b1; sample_chan = ch; sample_data = d;
    @(posedge ck); #1;
    sample_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge ck);
    #1;
    check("rst_ready",   {31'd0, ready},   32'd0);
    check("rst_ack",     {31'd0, ack},     32'd0);
    check("rst_rdt",     rdt,              32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    @(negedge ck);
    rst_n = 1'b1;
    #1 check("ready_before_edge", {31'd0, ready}, 32'd0);
    @(posedge ck); #1;
    check("ready_after_release", {31'd0, ready}, 32'd1);
    rd(A_STATUS, 32'h1, "status_reset");
    rd(A_RESULT, 32'h0, "result0_reset");
    rd(A_CAPT,   32'h0, "capture_reset");

    // CAPT mode0 captures the following program word
    load4(ins(5'd1, 8'd0, 3'd0, 16'h0), 32'h4808_1234, ins(5'd15, 8'd0, 3'd0, 16'h0), 32'h0);
    wr(A_RESET, 32'h0);
    check("busy_after_start", {31'd0, ready}, 32'd0);
    rd(A_STATUS, 32'h4, "status_busy");
    wait_ready("run_capt_done");
    rd(A_CAPT, 32'h4808_1234, "capt_next_word");
    rd(A_COEF + 32'd4, 32'h4808_1234, "coef_readback");

    // MACZ over channel 1, four frames back from wp=0, then SAVE >>> 15
    wr(A_STATUS, 32'h1);
    wr(A_INPUT + 32'h3F8, 32'h1234);
    load4(ins(5'd9, 8'd4, 3'd1, 16'h4000), ins(5'd10, 8'd15, 3'd0, 16'h0),
          ins(5'd15, 8'd0, 3'd0, 16'h0), 32'h0);
    wr(A_RESET, 32'h0);
    wait_ready("run_macz_done");
    rd(A_RESULT, 32'h0000_091A, "result0_macz");

    // INPUT writes are dropped while allow_audio_writes is clear
    wr(A_STATUS, 32'h0);
    wr(A_INPUT + 32'h3F8, 32'h5555);
    wr(A_STATUS, 32'h1);
    wr(A_RESET, 32'h0);
    wait_ready("run_drop_done");
    rd(A_RESULT, 32'h0000_091A, "input_dropped");

    // Two full-scale MACs, then SAVE >>> 15: saturate or wrap
    port_sample(3'd0, 16'h7FFF);
    load4(ins(5'd8, 8'd0, 3'd0, 16'h7FFF), ins(5'd8, 8'd0, 3'd0, 16'h7FFF),
          ins(5'd10, 8'd15, 3'd0, 16'h1), ins(5'd15, 8'd0, 3'd0, 16'h0));
    wr(A_RESET, 32'h0);
    wait_ready("run_big_done");
    rd(A_RESULT + 32'd4, EXP_SAVE_BIG, "result1_save_big");

    // frame_stb advances wp to 1 before the run starts
    wr(A_INPUT + 32'h2, 32'h0100);
    pulse_frame();
    check("busy_after_frame", {31'd0, ready}, 32'd0);
    wait_ready("run_frame_done");
    rd(A_RESULT + 32'd4, 32'h0000_01FF, "result1_after_frame");

    // Channel >= CHANNELS reads as zero
    load4(ins(5'd9, 8'd0, 3'd0, 16'h1), ins(5'd8, 8'd0, 3'd5, 16'h7FFF),
          ins(5'd10, 8'd0, 3'd0, 16'h2), ins(5'd15, 8'd0, 3'd0, 16'h0));
    wr(A_RESET, 32'h0);
    wait_ready("run_chan_done");
    rd(A_RESULT + 32'd8, 32'h0000_0100, "result2_bad_chan_zero");

    // Overrun: second frame_stb three cycles after the first
    pulse_frame();
    @(posedge ck);
    pulse_frame();
    check("overrun_set", {31'd0, overrun}, 32'd1);
    wait_ready("run_overrun_done");
    rd(A_STATUS, 32'h3, "status_overrun");
    wr(A_STATUS, 32'h3);
    rd(A_STATUS, 32'h1, "status_overrun_cleared");
    check("overrun_port_cleared", {31'd0, overrun}, 32'd0);

    // COEF write while busy is dropped; while idle it lands
    wr(A_RESET, 32'h0);
    wr(A_COEF, 32'hDEAD_BEEF);
    wait_ready("run_coeflock_done");
    rd(A_COEF, ins(5'd9, 8'd0, 3'd0, 16'h1), "coef_locked_busy");
    wr(A_COEF, 32'hDEAD_BEEF);
    rd(A_COEF, 32'hDEAD_BEEF, "coef_write_idle");

    // Reset in the middle of a run
    wr(A_RESET, 32'h0);
    pulse_frame();
    check("overrun_before_reset", {31'd0, overrun}, 32'd1);
    @(posedge ck); #1;
    rst_n = 1'b0;
    #1;
    check("midrun_rst_ready",   {31'd0, ready},   32'd0);
    check("midrun_rst_overrun", {31'd0, overrun}, 32'd0);
    check("midrun_rst_rdt",     rdt,              32'd0);
    check("midrun_rst_ack",     {31'd0, ack},     32'd0);
    @(negedge ck);
    rst_n = 1'b1;
    @(posedge ck); #1;
    check("midrun_ready_after_release", {31'd0, ready}, 32'd1);
    rd(A_STATUS, 32'h1, "status_after_midrun_rst");
    rd(A_RESULT, 32'h0, "result0_after_rst");
    rd(A_RESULT + 32'd4, 32'h0, "result1_after_rst");
    rd(A_CAPT, 32'h0, "capture_after_rst");

    repeat (5) @(posedge ck);
    if (exp_q.size() != 0) check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
